uart_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller between the CPU memory stage and the on-chip UART transmitter and receiver. It buffers received bytes and bytes awaiting transmission in small FIFOs, and drives the UART ready/valid handshakes. It also hosts the cycle and retired-instruction counters. It sits on the CPU data path, decoding the 0x8000_00xx address region alongside the BIOS, IMem and DMem address spaces.

---
 rtl/uart_mmio_ctrl_if.sv | 27 ++
 rtl/uart_mmio_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_ctrl_if.sv
// rtl/uart_mmio_ctrl_if.sv - CPU MMIO bus and UART handshake bundle for uart_mmio_ctrl
interface uart_mmio_ctrl_if;
  logic        mmio_en;
  logic [3:0]  mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        inst_retire;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  mmio_en, mmio_we, mmio_addr, mmio_wdata, inst_retire,
    input  tx_ready, rx_data, rx_valid,
    output mmio_rdata, tx_data, tx_valid, rx_ready
  );

  modport master (
    output mmio_en, mmio_we, mmio_addr, mmio_wdata, inst_retire,
    output tx_ready, rx_data, rx_valid,
    input  mmio_rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - MMIO controller: UART RX/TX FIFOs, status, cycle/instruction counters
module uart_mmio_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  uart_mmio_ctrl_if.slave  bus
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [27:0] OFF_STATUS = 28'h00;
  localparam logic [27:0] OFF_RXD    = 28'h04;
  localparam logic [27:0] OFF_TXD    = 28'h08;
  localparam logic [27:0] OFF_CYC    = 28'h10;
  localparam logic [27:0] OFF_INST   = 28'h14;
  localparam logic [27:0] OFF_CLR    = 28'h18;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]   rx_cnt, tx_cnt;
  logic [31:0]   cycle_cnt, inst_cnt;
  logic          overflow;

  logic          hit, rd_req, wr_req;
  logic [27:0]   offset;
  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          rx_push, rx_pop, tx_push, tx_pop, tx_ovf, cnt_clr;
  logic [31:0]   rd_value;
  logic          unused_wdata;

  assign hit    = bus.mmio_addr[31:28] == MMIO_BASE[31:28];
  assign offset = bus.mmio_addr[27:0];
  assign rd_req = bus.mmio_en && (bus.mmio_we == 4'b0000);
  assign wr_req = bus.mmio_en && (bus.mmio_we != 4'b0000) && hit;

  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == FULL_CNT;
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == FULL_CNT;

  assign bus.rx_ready = !rst && !rx_full;
  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_mem[tx_rd_ptr];

  // Fullness is judged at the start of the cycle, so a same-cycle TX pop never makes room.
  assign rx_push = bus.rx_valid && bus.rx_ready;
  assign rx_pop  = rd_req && hit && (offset == OFF_RXD) && !rx_empty;
  assign tx_push = wr_req && (offset == OFF_TXD) && bus.mmio_we[0] && !tx_full;
  assign tx_ovf  = wr_req && (offset == OFF_TXD) && bus.mmio_we[0] && tx_full;
  assign tx_pop  = bus.tx_valid && bus.tx_ready;
  assign cnt_clr = wr_req && (offset == OFF_CLR);

  assign unused_wdata = ^bus.mmio_wdata[31:8];

  always_comb begin
    rd_value = 32'h0;
    if (hit) begin
      case (offset)
        OFF_STATUS: rd_value = {29'h0, overflow, !rx_empty, !tx_full};
        OFF_RXD:    rd_value = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
        OFF_CYC:    rd_value = cycle_cnt;
        OFF_INST:   rd_value = inst_cnt;
        default:    rd_value = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.mmio_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (AW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (AW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (AW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (AW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // A clear wins over a same-cycle increment; a read in that cycle already sampled the old value.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt <= 32'h0;
      inst_cnt  <= 32'h0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (bus.inst_retire) inst_cnt <= inst_cnt + 32'h1;
      if (tx_ovf) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mmio_rdata <= 32'h0;
    end else if (rd_req) begin
      bus.mmio_rdata <= rd_value;
    end
  end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - scoreboard bench for uart_mmio_ctrl
module tb_uart_mmio_ctrl;
  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RXD    = 32'h8000_0004;
  localparam logic [31:0] A_TXD    = 32'h8000_0008;
  localparam logic [31:0] A_CYC    = 32'h8000_0010;
  localparam logic [31:0] A_INST   = 32'h8000_0014;
  localparam logic [31:0] A_CLR    = 32'h8000_0018;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rd_seen = 1'b0;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];

  uart_mmio_ctrl_if bus();

  uart_mmio_ctrl #(
    .FIFO_DEPTH(8),
    .MMIO_BASE (32'h8000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rd_seen <= !rst && bus.mmio_en && (bus.mmio_we == 4'b0000);

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        check("rd_q_underflow", rd_q.size(), 1);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check(e.tag, bus.mmio_rdata, e.exp);
      end
    end
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (tx_q.size() == 0) check("tx_unexpected_pop", tx_q.size(), 1);
      else check("tx_byte", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    e.tag = tag;
    e.exp = exp;
    rd_q.push_back(e);
    bus.mmio_en   = 1'b1;
    bus.mmio_we   = 4'b0000;
    bus.mmio_addr = addr;
    step();
    bus.mmio_en   = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    bus.mmio_en    = 1'b1;
    bus.mmio_we    = we;
    bus.mmio_addr  = addr;
    bus.mmio_wdata = data;
    step();
    bus.mmio_en    = 1'b0;
    bus.mmio_we    = 4'b0000;
  endtask

  task automatic rx_send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    bus.mmio_en     = 1'b0;
    bus.mmio_we     = 4'b0000;
    bus.mmio_addr   = 32'h0;
    bus.mmio_wdata  = 32'h0;
    bus.inst_retire = 1'b0;
    bus.tx_ready    = 1'b0;
    bus.rx_data     = 8'h0;
    bus.rx_valid    = 1'b0;

    idle(3);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_rdata", bus.mmio_rdata, 0);
    rst = 1'b0;

    cpu_read(A_STATUS, 32'h1, "st_reset");
    cpu_read(A_RXD, 32'h0, "rx_empty_read");
    cpu_read(A_STATUS, 32'h1, "st_no_pop");
    cpu_read(32'h4000_0000, 32'h0, "out_of_region");
    cpu_read(32'h8000_000C, 32'h0, "unmapped_offset");
    cpu_read(A_CLR, 32'h0, "clr_read");

    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      cpu_write(A_TXD, 32'h41 + i, 4'hF);
    end
    cpu_read(A_STATUS, 32'h0, "st_tx_full");
    cpu_write(A_TXD, 32'h49, 4'h1);
    cpu_read(A_STATUS, 32'h4, "st_overflow");
    check("tx_head", {24'h0, bus.tx_data}, 32'h41);
    bus.tx_ready = 1'b1;
    idle(10);
    check("tx_drained_valid", bus.tx_valid, 0);
    cpu_read(A_STATUS, 32'h5, "st_ovf_sticky");
    tx_q.push_back(8'h50);
    cpu_write(A_TXD, 32'h50, 4'h1);
    tx_q.push_back(8'h51);
    cpu_write(A_TXD, 32'hFFFF_FF51, 4'h1);
    cpu_write(A_TXD, 32'h52, 4'b0010);
    idle(3);
    check("tx_idle_valid", bus.tx_valid, 0);
    cpu_write(A_CLR, 32'h0, 4'b0100);
    cpu_read(A_STATUS, 32'h1, "st_ovf_cleared");
    bus.tx_ready = 1'b0;

    rx_send(8'h61);
    rx_send(8'h62);
    rx_send(8'h63);
    cpu_read(A_STATUS, 32'h3, "st_rx_data");
    cpu_read(A_RXD, 32'h61, "rx_a");
    cpu_read(A_RXD, 32'h62, "rx_b");
    cpu_read(A_RXD, 32'h63, "rx_c");
    cpu_read(A_RXD, 32'h0, "rx_after_c");
    cpu_read(A_STATUS, 32'h1, "st_rx_empty");

    for (int i = 0; i < 8; i++) rx_send(8'h10 + 8'(i));
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h18;
    idle(2);
    check("rx_ready_full", bus.rx_ready, 0);
    cpu_read(A_RXD, 32'h10, "rx_full_pop");
    check("rx_ready_after_pop", bus.rx_ready, 1);
    step();
    bus.rx_valid = 1'b0;
    for (int i = 1; i < 9; i++) cpu_read(A_RXD, 32'h10 + i, "rx_fill_seq");
    cpu_read(A_RXD, 32'h0, "rx_fill_drained");

    rx_send(8'h20);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h21;
    cpu_read(A_RXD, 32'h20, "rx_pushpop_head");
    bus.rx_valid = 1'b0;
    cpu_read(A_RXD, 32'h21, "rx_pushpop_next");
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h30;
    cpu_read(A_RXD, 32'h0, "rx_no_bypass");
    bus.rx_valid = 1'b0;
    cpu_read(A_RXD, 32'h30, "rx_after_no_bypass");

    cpu_write(A_CLR, 32'h0, 4'h1);
    for (int i = 0; i < 100; i++) begin
      bus.inst_retire = (i < 37);
      step();
    end
    bus.inst_retire = 1'b0;
    cpu_read(A_INST, 32'd37, "inst_cnt");
    cpu_read(A_CYC, 32'd101, "cycle_cnt");
    bus.inst_retire = 1'b1;
    cpu_write(A_CLR, 32'h0, 4'h8);
    bus.inst_retire = 1'b0;
    cpu_read(A_CYC, 32'h0, "cycle_after_clr");
    cpu_read(A_INST, 32'h0, "inst_after_clr");

    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'hA0 + 8'(i));
      cpu_write(A_TXD, 32'hA0 + i, 4'h1);
    end
    for (int i = 0; i < 4; i++) rx_send(8'hB0 + 8'(i));
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    rst = 1'b1;
    tx_q.delete();
    step();
    check("midrst_rx_ready", bus.rx_ready, 0);
    check("midrst_tx_valid", bus.tx_valid, 0);
    check("midrst_rdata", bus.mmio_rdata, 0);
    step();
    rst = 1'b0;
    cpu_read(A_STATUS, 32'h1, "st_after_rst");
    bus.rx_valid = 1'b0;
    check("tx_valid_after_rst", bus.tx_valid, 0);
    cpu_read(A_RXD, 32'h77, "rx_held_byte");
    cpu_read(A_RXD, 32'h0, "rx_no_stale");
    bus.tx_ready = 1'b1;
    idle(3);

    check("rd_q_left", rd_q.size(), 0);
    check("tx_q_left", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
